pic_bus_sequencer: RTL and testbench

Clocked, parametrised successor to the 8259A bus control logic. It synchronises the CPU bus strobes and decodes writes into one-cycle ICW/OCW strobes. A hardware sequencer tracks the ICW1→ICW2→(ICW3)→(ICW4) initialisation order. It also drives a registered read-back mux (IRR/ISR/IMR, optional poll word). It sits between the external 8-bit CPU bus and the register and priority blocks of the PIC.

---
 rtl/pic_bus_pkg.sv | 30 +++
 rtl/pic_sync_edge.sv | 31 +++
 rtl/pic_bus_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_pic_bus_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_bus_pkg.sv
// Shared state encoding, strobe bundle and ICW/OCW bit positions for the PIC bus sequencer.
package pic_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StExpIcw2,
    StExpIcw3,
    StExpIcw4,
    StOperational
  } state_e;

  typedef struct packed {
    logic icw1;
    logic icw2;
    logic icw3;
    logic icw4;
    logic ocw1;
    logic ocw2;
    logic ocw3;
  } strobe_t;

  localparam int unsigned ICW1_IC4  = 0;
  localparam int unsigned ICW1_SNGL = 1;
  localparam int unsigned ICW1_D4   = 4;
  localparam int unsigned OCW3_RIS  = 0;
  localparam int unsigned OCW3_RR   = 1;
  localparam int unsigned OCW3_P    = 2;
  localparam int unsigned OCW3_D3   = 3;

endpackage

// File: rtl/pic_sync_edge.sv
// Multi-stage synchroniser for one asynchronous bus control, with rise/fall detect.
// Resets to 1 so an undriven control reads as inactive.
module pic_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_bar,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/pic_bus_sequencer.sv
// 8259A-style bus control: synchronised strobes, ICW/OCW write decode, init sequencer and
// registered read-back mux. Optional poll-word read-back is enabled by defining PIC_POLL_EN.
module pic_bus_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset_bar,
  input  logic                  CS_bar,
  input  logic                  RD_bar,
  input  logic                  WR_bar,
  input  logic                  A0,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] data_bus_out,
  output logic                  data_bus_oe,
  input  logic [DATA_WIDTH-1:0] irr_in,
  input  logic [DATA_WIDTH-1:0] isr_in,
  input  logic [DATA_WIDTH-1:0] imr_in,
  output logic                  icw1_wr,
  output logic                  icw2_wr,
  output logic                  icw3_wr,
  output logic                  icw4_wr,
  output logic                  ocw1_wr,
  output logic                  ocw2_wr,
  output logic                  ocw3_wr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  single_mode,
  output logic                  icw4_needed,
  output logic                  init_done,
`ifdef PIC_POLL_EN
  input  logic [2:0]            poll_vector,
  input  logic                  poll_valid,
  output logic                  poll_ack,
`endif
  output logic                  read_done
);

  import pic_bus_pkg::*;

  logic       cs_s, rd_s, wr_s, a0_s;
  logic [3:0] unused_rise, unused_fall;

  pic_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clock(clock), .reset_bar(reset_bar), .raw(CS_bar),
    .level(cs_s), .rise(unused_rise[0]), .fall(unused_fall[0])
  );
  pic_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
    .clock(clock), .reset_bar(reset_bar), .raw(RD_bar),
    .level(rd_s), .rise(unused_rise[1]), .fall(unused_fall[1])
  );
  pic_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .clock(clock), .reset_bar(reset_bar), .raw(WR_bar),
    .level(wr_s), .rise(unused_rise[2]), .fall(unused_fall[2])
  );
  pic_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a0 (
    .clock(clock), .reset_bar(reset_bar), .raw(A0),
    .level(a0_s), .rise(unused_rise[3]), .fall(unused_fall[3])
  );

  logic write_active, read_active, write_fall, read_fall;
  logic write_active_q, read_active_q;

  assign write_active = ~wr_s & ~cs_s;
  assign read_active  = ~rd_s & ~cs_s & wr_s;  // a concurrent write suppresses the read
  assign write_fall   = write_active_q & ~write_active;
  assign read_fall    = read_active_q & ~read_active;

  logic [DATA_WIDTH-1:0] hold_data_q, write_data_q, write_data_d, data_out_q, data_out_d;
  logic                  hold_a0_q;
  state_e                state_q, state_d;
  strobe_t               strobe_q, strobe_d;
  logic                  single_q, single_d, ic4_q, ic4_d, read_sel_q, read_sel_d;
  logic                  read_done_q, read_done_d;
`ifdef PIC_POLL_EN
  logic                  poll_armed_q, poll_armed_d, poll_ack_q, poll_ack_d;
`endif

  always_comb begin
    state_d      = state_q;
    strobe_d     = '0;
    single_d     = single_q;
    ic4_d        = ic4_q;
    read_sel_d   = read_sel_q;
    write_data_d = write_data_q;
    read_done_d  = read_fall;
`ifdef PIC_POLL_EN
    poll_ack_d   = read_fall & poll_armed_q;
    poll_armed_d = poll_armed_q & ~read_fall;
`endif
    if (write_fall) begin
      if (!hold_a0_q && hold_data_q[ICW1_D4]) begin
        // ICW1 restarts initialisation from any state
        strobe_d.icw1 = 1'b1;
        single_d      = hold_data_q[ICW1_SNGL];
        ic4_d         = hold_data_q[ICW1_IC4];
        state_d       = StExpIcw2;
      end else begin
        unique case (state_q)
          StExpIcw2: if (hold_a0_q) begin
            strobe_d.icw2 = 1'b1;
            if (!single_q)  state_d = StExpIcw3;
            else if (ic4_q) state_d = StExpIcw4;
            else            state_d = StOperational;
          end
          StExpIcw3: if (hold_a0_q) begin
            strobe_d.icw3 = 1'b1;
            state_d       = ic4_q ? StExpIcw4 : StOperational;
          end
          StExpIcw4: if (hold_a0_q) begin
            strobe_d.icw4 = 1'b1;
            state_d       = StOperational;
          end
          StOperational: begin
            if (hold_a0_q) begin
              strobe_d.ocw1 = 1'b1;
            end else if (!hold_data_q[OCW3_D3]) begin
              strobe_d.ocw2 = 1'b1;
            end else begin
              strobe_d.ocw3 = 1'b1;
              if (hold_data_q[OCW3_RR]) read_sel_d = hold_data_q[OCW3_RIS];
`ifdef PIC_POLL_EN
              if (hold_data_q[OCW3_P]) poll_armed_d = 1'b1;
`endif
            end
          end
          default: ;
        endcase
      end
      if (|strobe_d) write_data_d = hold_data_q;
    end
  end

  always_comb begin
    data_out_d = '0;
    if (a0_s) begin
      data_out_d = imr_in;
`ifdef PIC_POLL_EN
    end else if (poll_armed_q) begin
      data_out_d[7:0] = {poll_valid, 4'b0000, poll_vector};
`endif
    end else if (read_sel_q) begin
      data_out_d = isr_in;
    end else begin
      data_out_d = irr_in;
    end
  end

  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      write_active_q <= 1'b0;
      read_active_q  <= 1'b0;
      hold_data_q    <= '0;
      hold_a0_q      <= 1'b0;
      state_q        <= StIdle;
      strobe_q       <= '0;
      single_q       <= 1'b0;
      ic4_q          <= 1'b0;
      read_sel_q     <= 1'b0;
      write_data_q   <= '0;
      read_done_q    <= 1'b0;
      data_out_q     <= '0;
    end else begin
      write_active_q <= write_active;
      read_active_q  <= read_active;
      if (write_active) begin
        hold_data_q <= data_bus_in;
        hold_a0_q   <= a0_s;
      end
      state_q      <= state_d;
      strobe_q     <= strobe_d;
      single_q     <= single_d;
      ic4_q        <= ic4_d;
      read_sel_q   <= read_sel_d;
      write_data_q <= write_data_d;
      read_done_q  <= read_done_d;
      data_out_q   <= data_out_d;
    end
  end

`ifdef PIC_POLL_EN
  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      poll_armed_q <= 1'b0;
      poll_ack_q   <= 1'b0;
    end else begin
      poll_armed_q <= poll_armed_d;
      poll_ack_q   <= poll_ack_d;
    end
  end

  assign poll_ack = poll_ack_q;
`endif

  assign icw1_wr      = strobe_q.icw1;
  assign icw2_wr      = strobe_q.icw2;
  assign icw3_wr      = strobe_q.icw3;
  assign icw4_wr      = strobe_q.icw4;
  assign ocw1_wr      = strobe_q.ocw1;
  assign ocw2_wr      = strobe_q.ocw2;
  assign ocw3_wr      = strobe_q.ocw3;
  assign write_data   = write_data_q;
  assign single_mode  = single_q;
  assign icw4_needed  = ic4_q;
  assign init_done    = (state_q == StOperational);
  assign read_done    = read_done_q;
  assign data_bus_out = data_out_q;
  // Drive enable comes straight from the pins so the bus turns around without sync delay
  assign data_bus_oe  = ~RD_bar & ~CS_bar & WR_bar;

endmodule

// File: tb/tb_pic_bus_sequencer.sv
// Scoreboard bench for pic_bus_sequencer: directed test-plan sequences followed by random bus
// traffic, checked against a queue-based model of the initialisation and read-back rules.
module tb_pic_bus_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned S  = 2;

  logic          clock = 1'b0;
  logic          reset_bar = 1'b0;
  logic          CS_bar = 1'b1, RD_bar = 1'b1, WR_bar = 1'b1, A0 = 1'b0;
  logic [DW-1:0] data_bus_in = '0, irr_in = '0, isr_in = '0, imr_in = '0;
  logic [DW-1:0] data_bus_out, write_data;
  logic          data_bus_oe, read_done, single_mode, icw4_needed, init_done;
  logic          icw1_wr, icw2_wr, icw3_wr, icw4_wr, ocw1_wr, ocw2_wr, ocw3_wr;
  logic          poll_ack_w;
`ifdef PIC_POLL_EN
  logic [2:0]    poll_vector = '0;
  logic          poll_valid = 1'b0;
  logic          poll_ack;
  assign poll_ack_w = poll_ack;
`else
  assign poll_ack_w = 1'b0;
`endif

  pic_bus_sequencer #(.DATA_WIDTH(DW), .SYNC_STAGES(S)) dut (
    .clock(clock), .reset_bar(reset_bar),
    .CS_bar(CS_bar), .RD_bar(RD_bar), .WR_bar(WR_bar), .A0(A0),
    .data_bus_in(data_bus_in), .data_bus_out(data_bus_out), .data_bus_oe(data_bus_oe),
    .irr_in(irr_in), .isr_in(isr_in), .imr_in(imr_in),
    .icw1_wr(icw1_wr), .icw2_wr(icw2_wr), .icw3_wr(icw3_wr), .icw4_wr(icw4_wr),
    .ocw1_wr(ocw1_wr), .ocw2_wr(ocw2_wr), .ocw3_wr(ocw3_wr),
    .write_data(write_data), .single_mode(single_mode), .icw4_needed(icw4_needed),
    .init_done(init_done),
`ifdef PIC_POLL_EN
    .poll_vector(poll_vector), .poll_valid(poll_valid), .poll_ack(poll_ack),
`endif
    .read_done(read_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Event kinds: 0..3 icw1..icw4, 4..6 ocw1..ocw3, 7 read_done, 8 poll_ack
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
    logic       init;
  } exp_t;

  exp_t sb[$];

  // Reference model: remaining ICWs kept as a list, plus operational flags
  int   pending[$];
  logic m_init = 1'b0;
  logic m_ris  = 1'b0;
  logic m_poll = 1'b0;

  task automatic push_event(input int kind, input logic [7:0] data, input int when);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = when;
    e.init = m_init;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    pending.delete();
    m_init = 1'b0;
    m_ris  = 1'b0;
    m_poll = 1'b0;
  endtask

  task automatic model_write(input logic a0v, input logic [7:0] d, input int rise_cyc);
    int k = -1;
    if (!a0v && d[4]) begin
      pending.delete();
      pending.push_back(2);
      if (!d[1]) pending.push_back(3);
      if (d[0]) pending.push_back(4);
      m_init = 1'b0;
      k = 0;
    end else if (pending.size() > 0) begin
      if (a0v) begin
        k = pending.pop_front() - 1;
        if (pending.size() == 0) m_init = 1'b1;
      end
    end else if (m_init) begin
      if (a0v) k = 4;
      else if (!d[3]) k = 5;
      else begin
        k = 6;
        if (d[1]) m_ris = d[0];
`ifdef PIC_POLL_EN
        if (d[2]) m_poll = 1'b1;
`endif
      end
    end
    if (k >= 0) push_event(k, d, rise_cyc + S + 1);
  endtask

  task automatic model_read(input logic a0v, input logic [7:0] irr, input logic [7:0] isr,
                            input logic [7:0] imr, input logic pval, input logic [2:0] pvec,
                            input int rise_cyc);
    logic [7:0] v;
    if (a0v) v = imr;
    else if (m_poll) v = {pval, 4'b0000, pvec};
    else v = m_ris ? isr : irr;
    push_event(7, v, rise_cyc + S + 1);
    if (m_poll) begin
      push_event(8, 8'h00, rise_cyc + S + 1);
      m_poll = 1'b0;
    end
  endtask

  // Monitor: pops one expectation per observed strobe/pulse
  logic [7:0] last_read = '0;
  logic [8:0] act;
  exp_t       mon_e;
  always @(negedge clock) begin
    if (reset_bar) begin
      if (data_bus_oe) last_read = data_bus_out[7:0];
      act = {poll_ack_w, read_done, ocw3_wr, ocw2_wr, ocw1_wr, icw4_wr, icw3_wr, icw2_wr, icw1_wr};
      for (int k = 0; k < 9; k++) begin
        if (act[k]) begin
          if (sb.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
          end else begin
            mon_e = sb.pop_front();
            check("event_kind", k, mon_e.kind);
            check("event_cycle", cyc, mon_e.cyc);
            if (k < 7) begin
              check("write_data", write_data[7:0], mon_e.data);
              check("init_done", init_done, mon_e.init);
            end
            if (k == 0) begin
              check("single_mode", single_mode, mon_e.data[1]);
              check("icw4_needed", icw4_needed, mon_e.data[0]);
            end
            if (k == 7) check("read_data", last_read, mon_e.data);
          end
        end
      end
    end
  end

  task automatic bus_write(input logic a0v, input logic [7:0] d);
    @(negedge clock);
    A0 = a0v;
    data_bus_in = d;
    CS_bar = 1'b0;
    WR_bar = 1'b0;
    repeat (S + 2) @(negedge clock);
    WR_bar = 1'b1;
    CS_bar = 1'b1;
    model_write(a0v, d, cyc);
    repeat (S + 3) @(negedge clock);
  endtask

  task automatic bus_read(input logic a0v, input logic [7:0] irr, input logic [7:0] isr,
                          input logic [7:0] imr, input logic pval, input logic [2:0] pvec);
    @(negedge clock);
    A0 = a0v;
    irr_in = irr;
    isr_in = isr;
    imr_in = imr;
`ifdef PIC_POLL_EN
    poll_valid  = pval;
    poll_vector = pvec;
`endif
    repeat (S + 2) @(negedge clock);
    CS_bar = 1'b0;
    RD_bar = 1'b0;
    #1 check("oe_during_read", data_bus_oe, 1'b1);
    repeat (S + 3) @(negedge clock);
    RD_bar = 1'b1;
    CS_bar = 1'b1;
    model_read(a0v, irr, isr, imr, pval, pvec, cyc);
    #1 check("oe_after_read", data_bus_oe, 1'b0);
    repeat (S + 3) @(negedge clock);
  endtask

  task automatic check_reset_state();
    check("rst_strobes", {icw1_wr, icw2_wr, icw3_wr, icw4_wr, ocw1_wr, ocw2_wr, ocw3_wr}, 0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_single_mode", single_mode, 1'b0);
    check("rst_icw4_needed", icw4_needed, 1'b0);
    check("rst_write_data", write_data, 0);
    check("rst_data_bus_out", data_bus_out, 0);
    check("rst_read_done", read_done, 1'b0);
    check("rst_poll_ack", poll_ack_w, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1 check_reset_state();
    @(negedge clock);
    reset_bar = 1'b1;
    repeat (3) @(negedge clock);

    // Single mode with ICW4
    bus_write(1'b0, 8'h13);
    bus_write(1'b1, 8'h20);
    bus_write(1'b1, 8'h01);
    check("init_after_icw4", init_done, 1'b1);

    // Cascade mode without ICW4
    bus_write(1'b0, 8'h10);
    bus_write(1'b1, 8'h08);
    check("init_before_icw3", init_done, 1'b0);
    bus_write(1'b1, 8'h04);
    check("init_after_icw3", init_done, 1'b1);

    // Select ISR, read it back
    bus_write(1'b0, 8'h0B);
    bus_read(1'b0, 8'h11, 8'h5A, 8'hC3, 1'b0, 3'd0);
    bus_read(1'b1, 8'h11, 8'h5A, 8'hC3, 1'b0, 3'd0);

    // OCW1, OCW2, OCW3 in order
    bus_write(1'b1, 8'hFF);
    bus_write(1'b0, 8'h20);
    bus_write(1'b0, 8'h08);

    // RD and WR together: write commits, read suppressed
    @(negedge clock);
    A0 = 1'b1;
    data_bus_in = 8'hA5;
    CS_bar = 1'b0;
    WR_bar = 1'b0;
    RD_bar = 1'b0;
    #1 check("oe_rd_wr_both_low", data_bus_oe, 1'b0);
    repeat (S + 2) @(negedge clock);
    WR_bar = 1'b1;
    RD_bar = 1'b1;
    CS_bar = 1'b1;
    model_write(1'b1, 8'hA5, cyc);
    repeat (S + 3) @(negedge clock);

    // ICW1 while expecting ICW3 restarts at ICW2
    bus_write(1'b0, 8'h10);
    bus_write(1'b1, 8'h08);
    bus_write(1'b0, 8'h12);
    bus_write(1'b1, 8'h30);
    check("init_after_restart", init_done, 1'b1);

    // Poll sequence; select IRR first
    bus_write(1'b0, 8'h0A);
    bus_write(1'b0, 8'h0C);
    bus_read(1'b0, 8'h33, 8'h44, 8'h55, 1'b1, 3'd5);
    bus_read(1'b0, 8'h66, 8'h77, 8'h88, 1'b0, 3'd2);

    // Reset in the middle of a write
    @(negedge clock);
    A0 = 1'b1;
    data_bus_in = 8'h77;
    CS_bar = 1'b0;
    WR_bar = 1'b0;
    repeat (S + 2) @(negedge clock);
    reset_bar = 1'b0;
    #1 check_reset_state();
    @(negedge clock);
    WR_bar = 1'b1;
    CS_bar = 1'b1;
    repeat (2) @(negedge clock);
    reset_bar = 1'b1;
    model_reset();
    repeat (S + 4) @(negedge clock);
    check("init_after_reset", init_done, 1'b0);

    // Non-ICW1 writes in IDLE are ignored, then re-initialise
    bus_write(1'b1, 8'h55);
    bus_write(1'b0, 8'h08);
    bus_write(1'b0, 8'h13);
    bus_write(1'b1, 8'h20);
    bus_write(1'b1, 8'h01);

    // Random traffic
    for (int i = 0; i < 120; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 3) begin
        bus_read(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                 3'($urandom));
      end else if (op == 3) begin
        bus_write(1'b0, 8'($urandom) | 8'h10);
      end else begin
        bus_write(1'($urandom), 8'($urandom));
      end
    end

    repeat (10) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
